// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU register-bus master: register map,
// controller states and bus-cycle phases.
package alu_bus_pkg;

  localparam logic [1:0] ADDR_RESULT = 2'b00;
  localparam logic [1:0] ADDR_A      = 2'b01;
  localparam logic [1:0] ADDR_B      = 2'b10;
  localparam logic [1:0] ADDR_OP     = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_ACCESS,
    WR_GAP,
    START,
    WAIT,
    RD_SETUP,
    RD_ACCESS,
    RD_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_ACCESS,
    X_GAP
  } xfer_phase_t;

  // Operand write order: A, then B, then opcode.
  function automatic logic [1:0] wr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    wr_addr = ADDR_A;
      2'd1:    wr_addr = ADDR_B;
      default: wr_addr = ADDR_OP;
    endcase
  endfunction

endpackage

// File: rtl/alu_bus_xfer.sv
// One register-bus cycle (setup / access / gap) for a write or a read.
// Address and write data stay put through the gap and clear once idle.
module alu_bus_xfer
  import alu_bus_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              cs,
  output logic              wr_enb,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data
);

  xfer_phase_t phase;
  logic        is_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= X_IDLE;
      is_wr   <= 1'b0;
      cs      <= 1'b0;
      wr_enb  <= 1'b0;
      rd_enb  <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
    end else if (start) begin
      phase   <= X_SETUP;
      is_wr   <= wr;
      cs      <= 1'b1;
      wr_enb  <= 1'b0;
      rd_enb  <= 1'b0;
      addr    <= addr_in;
      wr_data <= wr ? data_in : '0;
    end else begin
      case (phase)
        X_SETUP: begin
          phase  <= X_ACCESS;
          wr_enb <= is_wr;
          rd_enb <= !is_wr;
        end
        X_ACCESS: begin
          phase  <= X_GAP;
          cs     <= 1'b0;
          wr_enb <= 1'b0;
          rd_enb <= 1'b0;
        end
        X_GAP: begin
          phase   <= X_IDLE;
          addr    <= '0;
          wr_data <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_bus_master.sv
// Host-command to register-bus master: writes A, B and opcode, pulses
// op_start, waits, reads back the result and presents it to the host.
//
// state     | meaning
// IDLE      | waiting for cmd_valid; cmd_ready high
// WR_SETUP  | operand write, cs up, wr_enb low
// WR_ACCESS | operand write strobe
// WR_GAP    | cs low between writes; picks next operand or START
// START     | one-cycle op_start pulse
// WAIT      | OP_WAIT idle cycles for the ALU
// RD_SETUP  | result read, cs up, rd_enb low
// RD_ACCESS | result read strobe
// RD_WAIT   | RD_LATENCY cycles until rd_data is captured
// DONE      | result_valid pulse
module alu_bus_master
  import alu_bus_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 2,
  parameter int OP_WAIT    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_op,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic              cs,
  output logic              wr_enb,
  output logic              rd_enb,
  output logic              op_start,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int WAIT_CW = (OP_WAIT > 0) ? $clog2(OP_WAIT + 1) : 1;
  localparam int LAT_CW  = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

  state_t              state;
  logic [1:0]          idx;
  logic [WAIT_CW-1:0]  wait_cnt;
  logic [LAT_CW-1:0]   lat_cnt;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   op_q;

  logic                start_wr;
  logic                start_rd;
  logic [1:0]          nxt_idx;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;

  assign cmd_ready = (state == IDLE);

  // Bus-cycle requests fire on the edge that enters the matching setup state,
  // so the transfer unit runs in lockstep with this FSM.
  always_comb begin
    start_wr  = (cmd_valid && state == IDLE) || (state == WR_GAP && idx != 2'd2);
    start_rd  = (state == START && OP_WAIT == 0) || (state == WAIT && wait_cnt == '0);
    nxt_idx   = (state == IDLE) ? 2'd0 : idx + 2'd1;
    xfer_addr = start_wr ? ADDR_W'(wr_addr(nxt_idx)) : ADDR_W'(ADDR_RESULT);
    case (nxt_idx)
      2'd0:    xfer_data = cmd_a;
      2'd1:    xfer_data = b_q;
      default: xfer_data = op_q;
    endcase
  end

  alu_bus_xfer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_xfer (
    .clk     (clk),
    .rst     (rst),
    .start   (start_wr || start_rd),
    .wr      (start_wr),
    .addr_in (xfer_addr),
    .data_in (xfer_data),
    .cs      (cs),
    .wr_enb  (wr_enb),
    .rd_enb  (rd_enb),
    .addr    (addr),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      wait_cnt     <= '0;
      lat_cnt      <= '0;
      b_q          <= '0;
      op_q         <= '0;
      op_start     <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      op_start     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            b_q   <= cmd_b;
            op_q  <= cmd_op;
            idx   <= 2'd0;
            state <= WR_SETUP;
          end
        end
        WR_SETUP:  state <= WR_ACCESS;
        WR_ACCESS: state <= WR_GAP;
        WR_GAP: begin
          if (idx == 2'd2) begin
            idx      <= 2'd0;
            op_start <= 1'b1;
            state    <= START;
          end else begin
            idx   <= idx + 2'd1;
            state <= WR_SETUP;
          end
        end
        START: begin
          if (OP_WAIT == 0) begin
            state <= RD_SETUP;
          end else begin
            wait_cnt <= WAIT_CW'(OP_WAIT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RD_SETUP;
          else                wait_cnt <= wait_cnt - WAIT_CW'(1);
        end
        RD_SETUP: state <= RD_ACCESS;
        RD_ACCESS: begin
          if (RD_LATENCY == 0) begin
            result_data  <= rd_data;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            lat_cnt <= LAT_CW'(RD_LATENCY - 1);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            result_data  <= rd_data;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bus_master.sv
// Scoreboard bench for alu_bus_master: a memory-controller model answers the
// bus, a monitor checks bus writes, timing and results against a reference ALU.
module tb_alu_bus_master;

  localparam int DATA_W     = 4;
  localparam int ADDR_W     = 2;
  localparam int OP_WAIT    = 2;
  localparam int RD_LATENCY = 1;
  localparam int T_OPSTART  = 3 * 3 + 1;
  localparam int T_RESULT   = T_OPSTART + OP_WAIT + 2 + RD_LATENCY + 1;
  localparam int T_PERIOD   = T_RESULT + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a, cmd_b, cmd_op;
  logic              result_valid;
  logic [DATA_W-1:0] result_data;
  logic              cs, wr_enb, rd_enb, op_start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data = '0;

  alu_bus_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_WAIT(OP_WAIT), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .result_valid(result_valid), .result_data(result_data),
    .cs(cs), .wr_enb(wr_enb), .rd_enb(rd_enb), .op_start(op_start),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DATA_W-1:0] exp_res_q[$];
  logic [ADDR_W-1:0] exp_wa_q[$];
  logic [DATA_W-1:0] exp_wd_q[$];
  int                acc_q[$];
  int                acc_log[$];
  int                rv_log[$];
  logic [DATA_W-1:0] held = '0;
  logic [DATA_W-1:0] mem[4];
  int                rd_cnt = 0;
  logic              prev_cs = 0, prev_wr = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_wd = '0;

  // Reference ALU of the modelled memory controller.
  function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] op);
    case (op % 4)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, memory-controller model and scoreboard.
  always @(negedge clk) begin
    cyc++;
    rd_data <= '0;
    if (!rst) begin
      exp_res_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); acc_q.delete();
      held = '0;
      rd_cnt = 0;
      for (int i = 0; i < 4; i++) mem[i] = '0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) rd_data <= mem[0];
      end
      if (cmd_valid && cmd_ready) begin
        exp_res_q.push_back(alu_ref(cmd_a, cmd_b, cmd_op));
        exp_wa_q.push_back(2'b01); exp_wd_q.push_back(cmd_a);
        exp_wa_q.push_back(2'b10); exp_wd_q.push_back(cmd_b);
        exp_wa_q.push_back(2'b11); exp_wd_q.push_back(cmd_op);
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
      end
      if (cs && wr_enb) begin
        if (exp_wa_q.size() == 0) begin
          chk("unexpected_write", 32'(addr), 32'hFFFF);
        end else begin
          chk("write_addr", 32'(addr), 32'(exp_wa_q.pop_front()));
          chk("write_data", 32'(wr_data), 32'(exp_wd_q.pop_front()));
        end
        mem[addr] = wr_data;
      end
      if (cs && rd_enb) begin
        chk("read_addr", 32'(addr), 0);
        if (RD_LATENCY == 0) rd_data <= mem[0];
        else rd_cnt = RD_LATENCY;
      end
      if (op_start) begin
        mem[0] = alu_ref(mem[1], mem[2], mem[3]);
        chk("op_start_time", (acc_q.size() > 0) ? 32'(cyc - acc_q[0]) : 32'hFFFF, T_OPSTART);
      end
      if (result_valid) begin
        rv_log.push_back(cyc);
        if (exp_res_q.size() == 0) begin
          chk("unexpected_result_valid", 32'(result_data), 32'hFFFF);
        end else begin
          held = exp_res_q.pop_front();
          chk("result_data", 32'(result_data), 32'(held));
          chk("result_time", 32'(cyc - acc_q.pop_front()), T_RESULT);
        end
      end else begin
        chk("result_held", 32'(result_data), 32'(held));
      end
      chk("wr_and_rd", 32'(wr_enb && rd_enb), 0);
      chk("opstart_and_cs", 32'(op_start && cs), 0);
      if (cs && prev_cs) begin
        chk("addr_stable", 32'(addr), 32'(prev_addr));
        chk("wdata_stable", 32'(wr_data), 32'(prev_wd));
      end
      if (prev_wr) begin
        chk("gap_addr_stable", 32'(addr), 32'(prev_addr));
        chk("gap_wdata_stable", 32'(wr_data), 32'(prev_wd));
      end
      if (op_start || rd_enb || (cs && addr == '0)) chk("wdata_zero", 32'(wr_data), 0);
    end
    prev_cs = cs; prev_wr = wr_enb; prev_addr = addr; prev_wd = wr_data;
  end

  // Present a command (entered just after a rising edge); returns just after the accept edge.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] op, input bit keep);
    bit ok = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (exp_res_q.size() == 0 && cmd_ready) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n0, r0, gap;
    bit hit;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_result_data", 32'(result_data), 0);
    chk("rst_bus", 32'({cs, wr_enb, rd_enb, op_start, addr, wr_data}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed trace: A=1010 B=1010 op=0011 -> ~A = 0101.
    send(4'b1010, 4'b1010, 4'b0011, 0);
    drain();
    repeat (3) @(negedge clk);
    chk("directed_held", 32'(result_data), 32'h5);

    // cmd_valid held with operands changing every cycle.
    @(posedge clk); #1;
    n0 = acc_log.size();
    cmd_valid = 1'b1;
    cmd_a = DATA_W'($urandom); cmd_b = DATA_W'($urandom); cmd_op = DATA_W'($urandom);
    repeat (20) begin
      @(posedge clk); #1;
      cmd_a = DATA_W'($urandom); cmd_b = DATA_W'($urandom); cmd_op = DATA_W'($urandom);
    end
    cmd_valid = 1'b0;
    drain();
    chk("hold_accepts", 32'(acc_log.size() - n0), 2);
    gap = (acc_log.size() >= n0 + 2) ? acc_log[n0 + 1] - acc_log[n0] : -1;
    chk("hold_accept_gap", 32'(gap), T_PERIOD);

    // Reset during the B write strobe.
    @(posedge clk); #1;
    send(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), 0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (cs && wr_enb && addr == 2'b10) hit = 1;
    end
    chk("found_b_access", 32'(hit), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_bus", 32'({cs, wr_enb, rd_enb, op_start, addr, wr_data}), 0);
    chk("async_rst_result", 32'({result_valid, result_data}), 0);
    chk("async_rst_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    send(4'b0110, 4'b0011, 4'b0000, 0);
    drain();

    // Back-to-back commands.
    @(posedge clk); #1;
    r0 = rv_log.size();
    send(4'b0001, 4'b0010, 4'b0000, 1);
    send(4'b1111, 4'b0001, 4'b0001, 0);
    drain();
    chk("b2b_pulses", 32'(rv_log.size() - r0), 2);
    gap = (rv_log.size() >= r0 + 2) ? rv_log[r0 + 1] - rv_log[r0] : -1;
    chk("b2b_spacing", 32'(gap), T_PERIOD);

    // Random commands with random idle gaps.
    for (int k = 0; k < 12; k++) begin
      send(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_bus_master.md
ALU_BUS_MASTER -- requirements
Module: alu_bus_master

Interface
REQ-001 Parameter DATA_W, 4, width of bus data and operands.
REQ-002 Parameter ADDR_W, 2, width of bus register address.
REQ-003 Parameter OP_WAIT, 2, idle cycles after op_start before the result read begins.
REQ-004 Parameter RD_LATENCY, 1, cycles from the rd_enb access cycle to the rd_data capture edge.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  input  1  host requests one ALU operation.
REQ-008 cmd_ready  output  1  block idle and able to accept a command.
REQ-009 cmd_a, cmd_b  input  DATA_W  operands A and B.
REQ-010 cmd_op  input  DATA_W  ALU opcode.
REQ-011 result_valid  output  1  one-cycle pulse: result_data updated.
REQ-012 result_data  output  DATA_W  captured ALU result, held until the next capture.
REQ-013 cs, wr_enb, rd_enb, op_start  output  1  register-bus controls toward the memory controller.
REQ-014 addr  output  ADDR_W  register address: 00 result, 01 A, 10 B, 11 opcode.
REQ-015 wr_data  output  DATA_W  bus write data.
REQ-016 rd_data  input  DATA_W  bus read data.

Function
REQ-017 All outputs except cmd_ready SHALL be registered; cmd_ready SHALL equal (state == IDLE).
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_a/b/op SHALL be latched then, and later input changes SHALL be ignored.
REQ-019 cmd_valid while busy SHALL be ignored (not queued).
REQ-020 States: IDLE, WR_SETUP, WR_ACCESS, WR_GAP, START, WAIT, RD_SETUP, RD_ACCESS, RD_WAIT, DONE.
REQ-021 Writes SHALL occur in order A (01), B (10), opcode (11), selected by a 2-bit index; each is 3 cycles: WR_SETUP cs=1 wr_enb=0; WR_ACCESS cs=1 wr_enb=1; WR_GAP cs=0 wr_enb=0; addr/wr_data stable across all three.
REQ-022 After the third WR_GAP: START one cycle with op_start=1, cs=0; then WAIT for OP_WAIT cycles, all controls 0.
REQ-023 Read: RD_SETUP cs=1 rd_enb=0 addr=00; RD_ACCESS cs=1 rd_enb=1; RD_WAIT cs=0 for RD_LATENCY cycles; rd_data SHALL be captured into result_data at the final RD_WAIT edge.
REQ-024 DONE SHALL last one cycle with result_valid=1, then return to IDLE.
REQ-025 With defaults, result_valid SHALL be high in the cycle starting 16 edges after the accept edge; the next command is accepted no earlier than edge 17.
REQ-026 rd_enb and wr_enb SHALL never be high together; op_start SHALL never be high while cs=1.
REQ-027 wr_data SHALL be 0 in START, WAIT and all read states.
REQ-028 WAIT and RD_WAIT counters SHALL be wide enough for their parameter; a parameter value of 0 SHALL skip that state.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, cs=wr_enb=rd_enb=op_start=0, addr=0, wr_data=0, result_valid=0, result_data=0, index and counters 0.
REQ-030 Reset mid-operation SHALL abandon the transaction with no result_valid pulse; cmd_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 Package alu_bus_pkg SHALL hold the register address constants (ADDR_RESULT, ADDR_A, ADDR_B, ADDR_OP) and the state enumeration.
REQ-032 One sub-module, alu_bus_xfer, SHALL generate a single setup/access/gap bus cycle (write or read) on request, sequenced by the top FSM.

Verification
REQ-033 Accept A=1010, B=1010, op=0011 -> bus trace: (01,1010) setup/access/gap, (10,1010), (11,0011), op_start pulse, 2 idle, read addr 00, result_valid at edge 16.
REQ-034 Model returns rd_data=0101 at the capture edge, 0000 otherwise -> result_data=0101, held after result_valid falls.
REQ-035 cmd_valid held high with changing operands throughout a transaction -> only the first command executes, bus shows first operands, second accept at edge 17.
REQ-036 rst low during the B WR_ACCESS cycle -> all bus outputs 0 asynchronously, no result_valid, fresh command after release completes normally.
REQ-037 Two back-to-back commands (A=0001,B=0010,op=0000 then A=1111,B=0001,op=0001) -> two complete traces, two result_valid pulses 17 cycles apart.
REQ-038 Assertions throughout all tests: never wr_enb&rd_enb; never op_start&cs; addr/wr_data stable while cs=1.
